// File: rtl/pe_pkg.sv
// Shared constants and types for the PE sequencer slice.
package pe_pkg;

   localparam int DATA_W    = 16;
   localparam int ACC_IDX_W = 4;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_MAC,
      SEQ_DRAIN,
      SEQ_ROUND
   } seq_state_e;

   typedef enum logic [2:0] {
      CONN_S0, CONN_S1, CONN_S2, CONN_S3,
      CONN_S4, CONN_S5, CONN_S6, CONN_S7
   } conn_state_e;

   // A request for zero accumulators still uses one; oversize requests saturate.
   function automatic logic [ACC_IDX_W-1:0] clamp_nacc(input logic [3:0] n,
                                                      input logic [ACC_IDX_W-1:0] max_n);
      logic [ACC_IDX_W-1:0] r;
      if (n == 4'd0)
         r = ACC_IDX_W'(1);
      else if (n > max_n)
         r = max_n;
      else
         r = n;
      return r;
   endfunction

endpackage

// File: rtl/pe_seq_res_fifo.sv
// Synchronous show-ahead result FIFO holding {acc index, rounded data}, with occupancy count.
module pe_seq_res_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q < (AW+1)'(DEPTH)) || do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)
            count_q <= count_q + 1'b1;
         else if (do_pop && !do_push)
            count_q <= count_q - 1'b1;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/pe_sequencer.sv
// Command-driven operand streamer and result collector for one PE MAC unit.
// Optional PE_SEQ_PERF_EN adds perf_stall_cnt / perf_cmd_cnt counters.
module pe_sequencer #(
   parameter int DATA_W    = pe_pkg::DATA_W,
   parameter int NUM_ACC   = 8,
   parameter int LEN_W     = 8,
   parameter int RES_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [3:0]        cmd_nacc,
   input  logic [2:0]        cmd_conn,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] pe_data_in_1,
   output logic [DATA_W-1:0] pe_data_in_2,
   output logic [3:0]        pe_add_number,
   output logic              pe_acc_we,
   output logic              pe_acc_clr,
   output logic [3:0]        pe_round_number,
   output logic              pe_rounder_en,
   output logic [2:0]        pe_connection_state,
   input  logic [DATA_W-1:0] pe_data_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [3:0]        res_idx,
   output logic              busy
`ifdef PE_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_cmd_cnt
`endif
);
   import pe_pkg::*;

   localparam int CNT_W = $clog2(RES_DEPTH) + 1;

   seq_state_e           state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d, k_q, k_d;
   logic [ACC_IDX_W-1:0] nacc_q, nacc_d, idx_q, idx_d;
   conn_state_e          conn_q, conn_d;
   logic                 drain_q, drain_d;
   logic [ACC_IDX_W:0]   rd_cnt_q, rd_cnt_d;

   // Stage 1 feeds the PE multiplier; stage 2 lines up with its registered product.
   logic [DATA_W-1:0]    in1_q, in2_q;
   logic                 s1_we_q, s1_clr_q, s2_we_q, s2_clr_q;
   logic [ACC_IDX_W-1:0] s1_idx_q, s2_idx_q;
   logic                 cap_q;
   logic [ACC_IDX_W-1:0] cap_idx_q;

   logic                 zero_len, beat, last_beat;
   logic                 rd_pending, credit_ok, rd_issue, round_done;
   logic                 mac_stall, round_stall;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_empty, fifo_pop;
   logic [ACC_IDX_W+DATA_W-1:0] fifo_head;

   always_comb begin
      zero_len    = (len_q == '0);
      beat        = (state_q == SEQ_MAC) && (zero_len || op_valid);
      last_beat   = beat && (idx_q == nacc_q - 1'b1) && (zero_len || (k_q == len_q - 1'b1));
      credit_ok   = (int'(fifo_count) + int'(cap_q)) < RES_DEPTH;
      rd_pending  = (state_q == SEQ_ROUND) && (rd_cnt_q < {1'b0, nacc_q});
      rd_issue    = rd_pending && credit_ok;
      round_done  = (state_q == SEQ_ROUND) && !rd_pending && !cap_q;
      mac_stall   = (state_q == SEQ_MAC) && !op_valid;
      round_stall = rd_pending && !credit_ok;
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      nacc_d   = nacc_q;
      conn_d   = conn_q;
      k_d      = k_q;
      idx_d    = idx_q;
      drain_d  = drain_q;
      rd_cnt_d = rd_cnt_q;
      case (state_q)
         SEQ_IDLE: begin
            if (cmd_valid) begin
               state_d = SEQ_MAC;
               len_d   = cmd_len;
               nacc_d  = clamp_nacc(cmd_nacc, ACC_IDX_W'(NUM_ACC));
               conn_d  = conn_state_e'(cmd_conn);
               k_d     = '0;
               idx_d   = '0;
            end
         end
         SEQ_MAC: begin
            if (beat) begin
               if (idx_q == nacc_q - 1'b1) begin
                  idx_d = '0;
                  k_d   = k_q + 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            if (last_beat) begin
               state_d = SEQ_DRAIN;
               drain_d = 1'b0;
            end
         end
         SEQ_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d  = SEQ_ROUND;
               rd_cnt_d = '0;
            end
         end
         SEQ_ROUND: begin
            if (rd_issue)
               rd_cnt_d = rd_cnt_q + 1'b1;
            if (round_done)
               state_d = SEQ_IDLE;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= SEQ_IDLE;
         len_q     <= '0;
         nacc_q    <= '0;
         conn_q    <= CONN_S0;
         k_q       <= '0;
         idx_q     <= '0;
         drain_q   <= 1'b0;
         rd_cnt_q  <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         s1_we_q   <= 1'b0;
         s1_clr_q  <= 1'b0;
         s1_idx_q  <= '0;
         s2_we_q   <= 1'b0;
         s2_clr_q  <= 1'b0;
         s2_idx_q  <= '0;
         cap_q     <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         nacc_q    <= nacc_d;
         conn_q    <= conn_d;
         k_q       <= k_d;
         idx_q     <= idx_d;
         drain_q   <= drain_d;
         rd_cnt_q  <= rd_cnt_d;
         // Zero-length commands still write each accumulator, with a zero product.
         in1_q     <= (beat && !zero_len) ? op_a : '0;
         in2_q     <= (beat && !zero_len) ? op_b : '0;
         s1_we_q   <= beat;
         s1_clr_q  <= beat && (k_q == '0);
         s1_idx_q  <= beat ? idx_q : '0;
         s2_we_q   <= s1_we_q;
         s2_clr_q  <= s1_clr_q;
         s2_idx_q  <= s1_idx_q;
         cap_q     <= rd_issue;
         cap_idx_q <= rd_issue ? rd_cnt_q[ACC_IDX_W-1:0] : '0;
      end
   end

   pe_seq_res_fifo #(
      .WIDTH (ACC_IDX_W + DATA_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (cap_q),
      .push_data_i ({cap_idx_q, pe_data_out}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign fifo_pop            = res_valid && res_ready;
   assign res_valid           = !fifo_empty;
   assign res_data            = res_valid ? fifo_head[DATA_W-1:0] : '0;
   assign res_idx             = res_valid ? fifo_head[ACC_IDX_W+DATA_W-1:DATA_W] : '0;
   assign cmd_ready           = (state_q == SEQ_IDLE);
   assign op_ready            = (state_q == SEQ_MAC) && !zero_len;
   assign pe_data_in_1        = in1_q;
   assign pe_data_in_2        = in2_q;
   assign pe_add_number       = s2_idx_q;
   assign pe_acc_we           = s2_we_q;
   assign pe_acc_clr          = s2_clr_q;
   assign pe_rounder_en       = rd_issue;
   assign pe_round_number     = rd_issue ? rd_cnt_q[ACC_IDX_W-1:0] : '0;
   assign pe_connection_state = conn_q;
   assign busy                = (state_q != SEQ_IDLE) || !fifo_empty;

`ifdef PE_SEQ_PERF_EN
   logic [31:0] stall_cnt_q, cmd_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         cmd_cnt_q   <= '0;
      end else begin
         if (mac_stall || round_stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (round_done)
            cmd_cnt_q <= cmd_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_cmd_cnt   = cmd_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = ^{mac_stall, round_stall};
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural Q7.9 PE model attached.
module tb_pe_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_len;
   logic [3:0]  cmd_nacc;
   logic [2:0]  cmd_conn;
   logic        op_valid, op_ready;
   logic [15:0] op_a, op_b;
   logic [15:0] pe_data_in_1, pe_data_in_2;
   logic [3:0]  pe_add_number, pe_round_number;
   logic        pe_acc_we, pe_acc_clr, pe_rounder_en;
   logic [2:0]  pe_connection_state;
   logic [15:0] pe_data_out;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic [3:0]  res_idx;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pe_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_nacc(cmd_nacc), .cmd_conn(cmd_conn),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .pe_data_in_1(pe_data_in_1), .pe_data_in_2(pe_data_in_2),
      .pe_add_number(pe_add_number), .pe_acc_we(pe_acc_we), .pe_acc_clr(pe_acc_clr),
      .pe_round_number(pe_round_number), .pe_rounder_en(pe_rounder_en),
      .pe_connection_state(pe_connection_state), .pe_data_out(pe_data_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_idx(res_idx), .busy(busy)
   );

   // PE model: registered multiplier, accumulator bank, registered rounder.
   logic signed [31:0] prod_q;
   logic signed [31:0] acc_m [16];
   logic [15:0]        pe_out_q;

   always @(posedge clk) begin
      prod_q <= $signed(pe_data_in_1) * $signed(pe_data_in_2);
      if (pe_acc_we)
         acc_m[pe_add_number] <= pe_acc_clr ? prod_q : acc_m[pe_add_number] + prod_q;
      if (pe_rounder_en)
         pe_out_q <= 16'((acc_m[pe_round_number] + 32'sd256) >>> 9);
   end
   assign pe_data_out = pe_out_q;

   logic [15:0] got_data [$];
   logic [3:0]  got_idx  [$];
   int          rd_pulses;
   logic        op_ready_seen;

   always @(negedge clk) begin
      if (res_valid && res_ready) begin
         got_data.push_back(res_data);
         got_idx.push_back(res_idx);
         $display("result idx=%0d data=0x%04h", res_idx, res_data);
      end
      if (pe_rounder_en) rd_pulses++;
      if (op_ready) op_ready_seen = 1'b1;
   end

   task automatic send_cmd(input logic [7:0] len, input logic [3:0] nacc, input logic [2:0] conn);
      int n = 0;
      cmd_len = len; cmd_nacc = nacc; cmd_conn = conn; cmd_valid = 1'b1;
      while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
      total++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL cmd_accept timeout cmd_ready=%b expected 1", cmd_ready); bad++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("cmd len=%0d nacc=%0d conn=%0d", len, nacc, conn);
   endtask

   task automatic send_op(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      op_a = a; op_b = b; op_valid = 1'b1;
      while (!op_ready && n < 300) begin @(negedge clk); n++; end
      total++;
      if (op_ready !== 1'b1) begin
         $display("FAIL op_accept timeout op_ready=%b expected 1", op_ready); bad++;
      end
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin @(negedge clk); n++; end
      total++;
      if (busy !== 1'b0) begin
         $display("FAIL idle timeout busy=%b expected 0", busy); bad++;
      end
   endtask

   task automatic clear_results();
      got_data.delete();
      got_idx.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 0; cmd_len = 0; cmd_nacc = 0; cmd_conn = 0;
      op_valid = 0; op_a = 0; op_b = 0; res_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({op_ready, res_valid, busy, pe_acc_we, pe_acc_clr, pe_rounder_en, pe_add_number,
           pe_round_number, pe_connection_state, pe_data_in_1, pe_data_in_2, res_data, res_idx} !== '0) begin
         $display("FAIL reset_outputs got nonzero busy=%b we=%b in1=%h expected all 0", busy, pe_acc_we, pe_data_in_1); bad++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL reset_cmd_ready got=%b expected 1", cmd_ready); bad++;
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_acc();
      clear_results();
      send_cmd(8'd3, 4'd1, 3'd5);
      total++;
      if (pe_connection_state !== 3'd5) begin
         $display("FAIL conn_latch got=%0d expected 5", pe_connection_state); bad++;
      end
      op_a = 16'h0200; op_b = 16'h0200; op_valid = 1'b1;
      total++;
      if (op_ready !== 1'b1) begin
         $display("FAIL mac_op_ready got=%b expected 1", op_ready); bad++;
      end
      @(negedge clk);
      op_valid = 1'b0;
      total++;
      if (pe_data_in_1 !== 16'h0200 || pe_data_in_2 !== 16'h0200 || pe_acc_we !== 1'b0) begin
         $display("FAIL stage1_align in1=%h in2=%h we=%b expected 0200 0200 0", pe_data_in_1, pe_data_in_2, pe_acc_we); bad++;
      end
      @(negedge clk);
      total++;
      if (pe_acc_we !== 1'b1 || pe_acc_clr !== 1'b1 || pe_add_number !== 4'd0 || pe_data_in_1 !== 16'h0) begin
         $display("FAIL stage2_align we=%b clr=%b add=%0d in1=%h expected 1 1 0 0000", pe_acc_we, pe_acc_clr, pe_add_number, pe_data_in_1); bad++;
      end
      send_op(16'h0400, 16'h0100);
      send_op(16'hFE00, 16'h0200);
      wait_idle(100);
      total++;
      if (got_data.size() != 1 || got_data[0] !== 16'h0200 || got_idx[0] !== 4'd0) begin
         $display("FAIL single_acc count=%0d data=%h expected 1 result 0200 idx 0", got_data.size(), got_data.size() > 0 ? got_data[0] : 16'hxxxx); bad++;
      end
   endtask

   task automatic test_two_acc();
      logic [15:0] exp_d [2];
      exp_d[0] = 16'h0400; exp_d[1] = 16'h0800;
      clear_results();
      send_cmd(8'd2, 4'd2, 3'd1);
      send_op(16'h0200, 16'h0200);
      send_op(16'h0200, 16'h0400);
      send_op(16'h0200, 16'h0200);
      send_op(16'h0200, 16'h0400);
      wait_idle(100);
      total++;
      if (got_data.size() != 2) begin
         $display("FAIL two_acc_count got=%0d expected 2", got_data.size()); bad++;
      end
      for (int i = 0; i < 2 && i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== exp_d[i] || got_idx[i] !== 4'(i)) begin
            $display("FAIL two_acc[%0d] got idx=%0d data=%h expected idx=%0d data=%h", i, got_idx[i], got_data[i], i, exp_d[i]); bad++;
         end
      end
   endtask

   task automatic test_backpressure();
      clear_results();
      res_ready = 1'b0;
      rd_pulses = 0;
      send_cmd(8'd1, 4'd8, 3'd2);
      for (int i = 0; i < 8; i++) send_op(16'h0200, 16'((i + 1) * 512));
      repeat (30) @(negedge clk);
      total++;
      if (rd_pulses != 4) begin
         $display("FAIL bp_reads got=%0d expected 4", rd_pulses); bad++;
      end
      total++;
      if (pe_rounder_en !== 1'b0 || res_valid !== 1'b1 || got_data.size() != 0) begin
         $display("FAIL bp_stall rounder_en=%b res_valid=%b popped=%0d expected 0 1 0", pe_rounder_en, res_valid, got_data.size()); bad++;
      end
      res_ready = 1'b1;
      wait_idle(200);
      total++;
      if (got_data.size() != 8) begin
         $display("FAIL bp_count got=%0d expected 8", got_data.size()); bad++;
      end
      for (int i = 0; i < 8 && i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 16'((i + 1) * 512) || got_idx[i] !== 4'(i)) begin
            $display("FAIL bp_res[%0d] got idx=%0d data=%h expected idx=%0d data=%h", i, got_idx[i], got_data[i], i, 16'((i + 1) * 512)); bad++;
         end
      end
   endtask

   task automatic test_zero_len();
      clear_results();
      op_ready_seen = 1'b0;
      send_cmd(8'd0, 4'd3, 3'd0);
      wait_idle(100);
      total++;
      if (op_ready_seen !== 1'b0) begin
         $display("FAIL zero_len_op_ready got=%b expected 0", op_ready_seen); bad++;
      end
      total++;
      if (got_data.size() != 3) begin
         $display("FAIL zero_len_count got=%0d expected 3", got_data.size()); bad++;
      end
      for (int i = 0; i < 3 && i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 16'h0000 || got_idx[i] !== 4'(i)) begin
            $display("FAIL zero_len[%0d] got idx=%0d data=%h expected idx=%0d data=0000", i, got_idx[i], got_data[i], i); bad++;
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_results();
      send_cmd(8'd4, 4'd2, 3'd6);
      send_op(16'h0200, 16'h0200);
      send_op(16'h0200, 16'h0400);
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({op_ready, res_valid, busy, pe_acc_we, pe_acc_clr, pe_rounder_en, pe_add_number,
           pe_round_number, pe_connection_state, pe_data_in_1, pe_data_in_2, res_data, res_idx} !== '0) begin
         $display("FAIL midreset_outputs busy=%b we=%b in1=%h conn=%0d expected all 0", busy, pe_acc_we, pe_data_in_1, pe_connection_state); bad++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL midreset_cmd_ready got=%b expected 1", cmd_ready); bad++;
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (got_data.size() != 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL midreset_stale results=%0d res_valid=%b busy=%b expected 0 0 0", got_data.size(), res_valid, busy); bad++;
      end
   endtask

   task automatic test_back_to_back();
      clear_results();
      send_cmd(8'd1, 4'd0, 3'd3);
      send_op(16'h0200, 16'h0600);
      send_cmd(8'd2, 4'd1, 3'd4);
      send_op(16'h0200, 16'h0200);
      send_op(16'h0200, 16'h0100);
      wait_idle(100);
      total++;
      if (got_data.size() != 2) begin
         $display("FAIL b2b_count got=%0d expected 2", got_data.size()); bad++;
      end else begin
         total++;
         if (got_data[0] !== 16'h0600 || got_idx[0] !== 4'd0) begin
            $display("FAIL b2b_first got idx=%0d data=%h expected idx=0 data=0600", got_idx[0], got_data[0]); bad++;
         end
         total++;
         if (got_data[1] !== 16'h0300 || got_idx[1] !== 4'd0) begin
            $display("FAIL b2b_second got idx=%0d data=%h expected idx=0 data=0300", got_idx[1], got_data[1]); bad++;
         end
      end
   endtask

   initial begin
      rd_pulses     = 0;
      op_ready_seen = 1'b0;
      test_reset();
      test_single_acc();
      test_two_acc();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
